// File: rtl/crc_pkg.sv
// Shared types and the single-bit CRC step used by the serial CRC generator.
package crc_pkg;

  typedef enum logic [1:0] {IDLE, CALC, SHIFT} crc_state_t;

  localparam int CRC_MAX_W = 32;

  // Operands are zero-extended to CRC_MAX_W; the zero fill of >> keeps narrower CRCs exact.
  function automatic logic [CRC_MAX_W-1:0] crc_step(input logic [CRC_MAX_W-1:0] lfsr,
                                                    input logic                 din,
                                                    input logic [CRC_MAX_W-1:0] poly);
    logic fb;
    fb = lfsr[0] ^ din;
    return (lfsr >> 1) ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/crc_lfsr_core.sv
// Right-shifting CRC register: DATA_W chained steps per enable, seed reload and plain shift-out.
module crc_lfsr_core
  import crc_pkg::*;
#(
  parameter int              WIDTH  = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'hC4,
  parameter logic [WIDTH-1:0] SEED  = 8'hD8,
  parameter int              DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_en,
  input  logic              load_seed,
  input  logic              shift_out,
  input  logic [DATA_W-1:0] data,
  output logic [WIDTH-1:0]  lfsr
);

  localparam logic [CRC_MAX_W-1:0] POLY_EXT = CRC_MAX_W'(POLY);

  logic [CRC_MAX_W-1:0] step_acc;

  always_comb begin
    step_acc = CRC_MAX_W'(lfsr);
    for (int i = 0; i < DATA_W; i++) begin
      step_acc = crc_step(step_acc, data[i], POLY_EXT);
    end
  end

  generate
    if (WIDTH < CRC_MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^step_acc[CRC_MAX_W-1:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || load_seed) begin
      lfsr <= SEED;
    end else if (step_en) begin
      lfsr <= step_acc[WIDTH-1:0];
    end else if (shift_out) begin
      lfsr <= lfsr >> 1;
    end
  end

endmodule

// File: rtl/crc_serial_gen.sv
// Serial CRC generator: folds message bits while ACTIVE, then emits the CRC LSB-first for WIDTH cycles.
module crc_serial_gen
  import crc_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] POLY    = 8'hC4,
  parameter logic [WIDTH-1:0] SEED    = 8'hD8,
  parameter int               DATA_W  = 1,
  parameter logic [WIDTH-1:0] XOR_OUT = 8'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ACTIVE,
  input  logic [DATA_W-1:0] DATA,
  output logic              CRC,
  output logic              Valid,
  output logic              BUSY,
  output logic              OVERRUN,
  output crc_state_t        state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  // Padded so the bit counter can index the output mask directly.
  localparam logic [(1 << CW)-1:0] XOR_EXT = (1 << CW)'(XOR_OUT);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] lfsr;
  logic             step_en;
  logic             load_seed;
  logic             shift_out;

  assign step_en   = ACTIVE && (state != SHIFT);
  assign load_seed = (state == SHIFT) && (cnt == CNT_LAST);
  assign shift_out = ((state == CALC) && !ACTIVE) || ((state == SHIFT) && (cnt != CNT_LAST));
  assign BUSY      = (state != IDLE);

  crc_lfsr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED),
    .DATA_W(DATA_W)
  ) u_core (
    .clk      (CLK),
    .rst      (RST),
    .step_en  (step_en),
    .load_seed(load_seed),
    .shift_out(shift_out),
    .data     (DATA),
    .lfsr     (lfsr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      CRC     <= 1'b0;
      Valid   <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ACTIVE) state <= CALC;
        end
        CALC: begin
          if (!ACTIVE) begin
            state <= SHIFT;
            CRC   <= lfsr[0] ^ XOR_EXT[0];
            Valid <= 1'b1;
            cnt   <= CW'(1);
          end
        end
        SHIFT: begin
          if (ACTIVE) OVERRUN <= 1'b1;
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            CRC   <= 1'b0;
            Valid <= 1'b0;
            cnt   <= '0;
          end else begin
            CRC <= lfsr[0] ^ XOR_EXT[cnt];
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
